lru_victim_ctrl: RTL and testbench

- Set-associative cache controller stage that sits directly upstream of the LRU tracker.
- Accepts hit-update and miss requests from the cache lookup pipeline and drives the LRU tracker's index, access and access_valid inputs with the tracker's one-cycle BRAM read latency honoured.
- On a miss it consumes the tracker's one-hot lru output together with the set's valid and dirty bits. It selects a victim way, offers it to the refill/writeback engine, then marks that way most-recently-used.

---
 rtl/lru_victim_ctrl_pkg.sv | 29 ++
 rtl/lru_victim_ctrl_victim_pick.sv | 36 +++
 rtl/lru_victim_ctrl.sv | 96 +++++++++
 tb/tb_lru_victim_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lru_victim_ctrl_pkg.sv
// Shared cache definitions: way/index defaults, width helper, controller state encoding.
// No logic of its own; imported by the controller, the victim selector and the tracker.
// Defaults here must match the LRU tracker's build parameters.
package lru_victim_ctrl_pkg;

    localparam int CACHE_WAYS       = 4;
    localparam int CACHE_INDEX_BITS = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HIT_RD   = 3'd1,
        ST_HIT_UPD  = 3'd2,
        ST_MISS_RD  = 3'd3,
        ST_MISS_SEL = 3'd4,
        ST_OFFER    = 3'd5,
        ST_MISS_UPD = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/lru_victim_ctrl_victim_pick.sv
// Victim way select: lowest invalid way first, else lowest set bit of the LRU vector, else way 0.
// Purely combinational, zero latency.
// No handshake; the caller samples the result when its inputs are stable.
module victim_pick
    import lru_victim_ctrl_pkg::*;
#(
    parameter  int WIDTH    = CACHE_WAYS,
    localparam int WAY_BITS = log2(WIDTH)
) (
    input  logic [WIDTH-1:0]    set_valid,
    input  logic [WIDTH-1:0]    set_dirty,
    input  logic [WIDTH-1:0]    lru,
    output logic [WAY_BITS-1:0] victim_way,
    output logic                victim_dirty
);

    logic                any_invalid;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] lru_way;

    assign any_invalid = ~&set_valid;

    // Descending scans so the lowest matching index wins; all-zero falls through to 0.
    always_comb begin
        inv_way = '0;
        lru_way = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!set_valid[i]) inv_way = WAY_BITS'(i);
            if (lru[i])        lru_way = WAY_BITS'(i);
        end
    end

    assign victim_way   = any_invalid ? inv_way : lru_way;
    assign victim_dirty = set_valid[victim_way] & set_dirty[victim_way];

endmodule

// File: rtl/lru_victim_ctrl.sv
// Cache controller stage feeding the LRU tracker: hit updates and miss victim selection.
// Accept to lru_access_valid: hit 2 cycles, miss 4 cycles plus victim offer stall.
// req_ready only in IDLE; victim held in OFFER until victim_ready.
module lru_victim_ctrl
    import lru_victim_ctrl_pkg::*;
#(
    parameter  int WIDTH      = CACHE_WAYS,
    parameter  int INDEX_BITS = CACHE_INDEX_BITS,
    localparam int WAY_BITS   = log2(WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_hit,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [WAY_BITS-1:0]   req_way,
    output logic                  req_ready,
    input  logic [WIDTH-1:0]      set_valid,
    input  logic [WIDTH-1:0]      set_dirty,
    input  logic [WIDTH-1:0]      lru,
    output logic [INDEX_BITS-1:0] lru_index,
    output logic [WAY_BITS-1:0]   lru_access,
    output logic                  lru_access_valid,
    output logic                  victim_valid,
    output logic [WAY_BITS-1:0]   victim_way,
    output logic                  victim_dirty,
    input  logic                  victim_ready
);

    ctrl_state_t         state, state_nxt;
    logic [WAY_BITS-1:0] way_q;
    logic [WAY_BITS-1:0] pick_way;
    logic                pick_dirty;

    victim_pick #(.WIDTH(WIDTH)) u_victim_pick (
        .set_valid    (set_valid),
        .set_dirty    (set_dirty),
        .lru          (lru),
        .victim_way   (pick_way),
        .victim_dirty (pick_dirty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lru_index    <= '0;
            way_q        <= '0;
            victim_way   <= '0;
            victim_dirty <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_valid) begin
                lru_index <= req_index;
                way_q     <= req_way;
            end
            // Victim is frozen here so it stays stable for the whole offer.
            if (state == ST_MISS_SEL) begin
                victim_way   <= pick_way;
                victim_dirty <= pick_dirty;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        req_ready        = 1'b0;
        lru_access       = '0;
        lru_access_valid = 1'b0;
        victim_valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_hit ? ST_HIT_RD : ST_MISS_RD;
            end
            ST_HIT_RD:   state_nxt = ST_HIT_UPD;
            ST_HIT_UPD: begin
                lru_access       = way_q;
                lru_access_valid = 1'b1;
                state_nxt        = ST_IDLE;
            end
            ST_MISS_RD:  state_nxt = ST_MISS_SEL;
            ST_MISS_SEL: state_nxt = ST_OFFER;
            ST_OFFER: begin
                victim_valid = 1'b1;
                if (victim_ready) state_nxt = ST_MISS_UPD;
            end
            ST_MISS_UPD: begin
                lru_access       = victim_way;
                lru_access_valid = 1'b1;
                state_nxt        = ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lru_victim_ctrl.sv
// Directed bench for lru_victim_ctrl: hit/miss sequencing, victim priority, stall and reset.
module tb_lru_victim_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_hit;
    logic [7:0] req_index;
    logic [1:0] req_way;
    logic       req_ready;
    logic [3:0] set_valid;
    logic [3:0] set_dirty;
    logic [3:0] lru;
    logic [7:0] lru_index;
    logic [1:0] lru_access;
    logic       lru_access_valid;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       victim_dirty;
    logic       victim_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    lru_victim_ctrl #(.WIDTH(4), .INDEX_BITS(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_hit          (req_hit),
        .req_index        (req_index),
        .req_way          (req_way),
        .req_ready        (req_ready),
        .set_valid        (set_valid),
        .set_dirty        (set_dirty),
        .lru              (lru),
        .lru_index        (lru_index),
        .lru_access       (lru_access),
        .lru_access_valid (lru_access_valid),
        .victim_valid     (victim_valid),
        .victim_way       (victim_way),
        .victim_dirty     (victim_dirty),
        .victim_ready     (victim_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; checks and input changes happen here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic hit, input logic [7:0] idx, input logic [1:0] way);
        req_valid = 1'b1;
        req_hit   = hit;
        req_index = idx;
        req_way   = way;
    endtask

    // Runs a miss accepted in the current cycle with victim_ready already high;
    // checks the offered victim in cycle 3 and the tracker update in cycle 4.
    task automatic run_miss(input string tag, input logic [7:0] idx,
                            input logic [3:0] v, input logic [3:0] d, input logic [3:0] l,
                            input logic [1:0] exp_way, input logic exp_dirty);
        set_valid    = v;
        set_dirty    = d;
        lru          = l;
        victim_ready = 1'b1;
        chk({tag, "_ready0"}, 32'(req_ready), 32'd1);
        present(1'b0, idx, 2'd3);
        tick();                                   // cycle 1
        req_valid = 1'b0;
        chk({tag, "_idx1"}, 32'(lru_index), 32'(idx));
        chk({tag, "_av1"}, 32'(lru_access_valid), 32'd0);
        tick();                                   // cycle 2
        chk({tag, "_vv2"}, 32'(victim_valid), 32'd0);
        tick();                                   // cycle 3
        chk({tag, "_vv3"}, 32'(victim_valid), 32'd1);
        chk({tag, "_way3"}, 32'(victim_way), 32'(exp_way));
        chk({tag, "_dirty3"}, 32'(victim_dirty), 32'(exp_dirty));
        tick();                                   // cycle 4
        chk({tag, "_av4"}, 32'(lru_access_valid), 32'd1);
        chk({tag, "_acc4"}, 32'(lru_access), 32'(exp_way));
        chk({tag, "_vv4"}, 32'(victim_valid), 32'd0);
        tick();                                   // cycle 5
        chk({tag, "_av5"}, 32'(lru_access_valid), 32'd0);
        chk({tag, "_rdy5"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_hit      = 1'b0;
        req_index    = '0;
        req_way      = '0;
        set_valid    = '0;
        set_dirty    = '0;
        lru          = '0;
        victim_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_idx", 32'(lru_index), 32'd0);
        chk("rst_av", 32'(lru_access_valid), 32'd0);
        chk("rst_vv", 32'(victim_valid), 32'd0);

        // Hit: index 0x12, way 2.
        present(1'b1, 8'h12, 2'd2);
        tick();                                   // cycle 1
        req_valid = 1'b0;
        chk("hit_idx1", 32'(lru_index), 32'h12);
        chk("hit_av1", 32'(lru_access_valid), 32'd0);
        chk("hit_rdy1", 32'(req_ready), 32'd0);
        tick();                                   // cycle 2
        chk("hit_av2", 32'(lru_access_valid), 32'd1);
        chk("hit_acc2", 32'(lru_access), 32'd2);
        chk("hit_idx2", 32'(lru_index), 32'h12);
        tick();                                   // cycle 3
        chk("hit_av3", 32'(lru_access_valid), 32'd0);
        chk("hit_rdy3", 32'(req_ready), 32'd1);

        // Miss, all valid: LRU way 2 chosen, dirty.
        run_miss("miss_lru", 8'h05, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1'b1);
        // Miss, way 2 invalid: preferred over LRU way 0 and never dirty.
        run_miss("miss_inv", 8'h21, 4'b1011, 4'b1111, 4'b0001, 2'd2, 1'b0);

        // Miss with refill engine stalling 5 cycles.
        set_valid    = 4'b1111;
        set_dirty    = 4'b0000;
        lru          = 4'b1000;
        victim_ready = 1'b0;
        present(1'b0, 8'h33, 2'd0);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            chk("stall_rdy_pre", 32'(req_ready), 32'd0);
            chk("stall_av_pre", 32'(lru_access_valid), 32'd0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            chk("stall_vv", 32'(victim_valid), 32'd1);
            chk("stall_way", 32'(victim_way), 32'd3);
            chk("stall_dirty", 32'(victim_dirty), 32'd0);
            chk("stall_rdy", 32'(req_ready), 32'd0);
            chk("stall_av", 32'(lru_access_valid), 32'd0);
            if (k == 5) victim_ready = 1'b1;
            tick();
        end
        chk("stall_av_upd", 32'(lru_access_valid), 32'd1);
        chk("stall_acc_upd", 32'(lru_access), 32'd3);
        chk("stall_vv_upd", 32'(victim_valid), 32'd0);
        tick();
        chk("stall_av_after", 32'(lru_access_valid), 32'd0);

        // Back-to-back hit then miss on index 0x07; tracker reports corrupt all-zero lru.
        present(1'b1, 8'h07, 2'd1);
        tick();                                   // cycle 1
        req_valid = 1'b0;
        tick();                                   // cycle 2
        chk("b2b_hit_av", 32'(lru_access_valid), 32'd1);
        chk("b2b_hit_acc", 32'(lru_access), 32'd1);
        tick();                                   // cycle 3: first IDLE
        run_miss("b2b_miss", 8'h07, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1);

        // Reset asserted while a victim is on offer.
        set_valid    = 4'b1111;
        set_dirty    = 4'b0010;
        lru          = 4'b0010;
        victim_ready = 1'b0;
        present(1'b0, 8'h44, 2'd0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rmid_vv_pre", 32'(victim_valid), 32'd1);
        chk("rmid_way_pre", 32'(victim_way), 32'd1);
        chk("rmid_dirty_pre", 32'(victim_dirty), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmid_vv", 32'(victim_valid), 32'd0);
        chk("rmid_way", 32'(victim_way), 32'd0);
        chk("rmid_dirty", 32'(victim_dirty), 32'd0);
        chk("rmid_idx", 32'(lru_index), 32'd0);
        chk("rmid_av", 32'(lru_access_valid), 32'd0);
        chk("rmid_acc", 32'(lru_access), 32'd0);
        victim_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rmid_rdy_after", 32'(req_ready), 32'd1);
            chk("rmid_av_after", 32'(lru_access_valid), 32'd0);
            chk("rmid_vv_after", 32'(victim_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
